// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM phase encoding and the
// leading-zero visibility helper for the scan controller.
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W = 3;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_t;

  // Visible digits for leading-zero blanking:
  // everything at or below the top nonzero nibble,
  // digit 0 always, plus any digit with its dp lit.
  function automatic logic [7:0] lz_visible(
    input logic [31:0] v,
    input logic [7:0]  dp
  );
    logic [7:0] vis;
    logic       seen;
    vis  = '0;
    seen = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      seen   = seen | (v[k*4 +: 4] != 4'h0);
      vis[k] = seen | dp[k];
    end
    vis[0] = 1'b1;
    return vis;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-word handshake bundle.
// master: value_in, dp_in, value_valid out; value_ready in.
// slave : the reverse.
interface seven_seg_scan_ctrl_if;

  logic [31:0] value_in;
  logic [7:0]  dp_in;
  logic        value_valid;
  logic        value_ready;

  modport master (
    output value_in,
    output dp_in,
    output value_valid,
    input  value_ready
  );

  modport slave (
    input  value_in,
    input  dp_in,
    input  value_valid,
    output value_ready
  );

endinterface

// File: rtl/seven_seg_slot_timer.sv
// Slot counter, digit index and BLANK/DRIVE phase FSM.
// Ports: clk, reset (async high);
//   o_idx_nxt   digit index after the coming edge
//   o_drive_nxt phase after the coming edge is DRIVE
//   o_slot_wrap last cycle of the current slot
//   o_frame_end last cycle of the last digit's slot
module seven_seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic             clk,
  input  logic             reset,
  output logic [IDX_W-1:0] o_idx_nxt,
  output logic             o_drive_nxt,
  output logic             o_slot_wrap,
  output logic             o_frame_end
);

  localparam int CNT_W =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST =
    CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] r_idx;
  phase_t           r_state;
  phase_t           w_state_nxt;
  logic             r_frame_end;
  logic             w_wrap;

  assign w_wrap    = (r_cnt == CNT_LAST);
  assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;

  always_comb begin
    o_idx_nxt = r_idx;
    if (w_wrap) begin
      o_idx_nxt = (r_idx == IDX_LAST) ?
                  '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      BLANK: begin
        if (r_cnt == BLK_LAST && !w_wrap)
          w_state_nxt = DRIVE;
      end
      DRIVE: begin
        if (w_wrap)
          w_state_nxt = BLANK;
      end
      default: w_state_nxt = BLANK;
    endcase
  end

  // frame_end is looked ahead one cycle so the
  // registered strobe lines up with the wrap cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_state     <= BLANK;
      r_frame_end <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_idx       <= o_idx_nxt;
      r_state     <= w_state_nxt;
      r_frame_end <= (w_cnt_nxt == CNT_LAST) &&
                     (o_idx_nxt == IDX_LAST);
    end
  end

  assign o_drive_nxt = (w_state_nxt == DRIVE);
  assign o_slot_wrap = w_wrap;
  assign o_frame_end = r_frame_end;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// 8-digit seven-segment scan controller; frame-synchronous
// word update via valid/ready, active-low anode drive.
// Ports: clk, reset (async high), bus (slave modport:
//   value_in, dp_in, value_valid, value_ready),
//   digit_en, hex_out, anode_n, dp_n, frame_done.
// Optional: LEADING_ZERO_BLANK_EN hides leading zeros.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  seven_seg_scan_ctrl_if.slave  bus,
  input  logic [7:0]            digit_en,
  output logic [3:0]            hex_out,
  output logic [7:0]            anode_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_drive_nxt;
  logic             w_wrap;
  logic             w_frame_end;

  seven_seg_slot_timer #(
    .TICK_DIV     (TICK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .o_idx_nxt   (w_idx_nxt),
    .o_drive_nxt (w_drive_nxt),
    .o_slot_wrap (w_wrap),
    .o_frame_end (w_frame_end)
  );

  logic [31:0] r_disp;
  logic [31:0] r_pend;
  logic [31:0] w_disp_nxt;
  logic [7:0]  r_dp_disp;
  logic [7:0]  r_dp_pend;
  logic [7:0]  w_dp_nxt;
  logic [7:0]  w_vis_nxt;
  logic        r_pend_full;
  logic        w_accept;
  logic        w_commit;
  logic [3:0]  w_nib;
  logic [7:0]  w_anode_nxt;
  logic [3:0]  r_hex;
  logic [7:0]  r_anode_n;
  logic        r_dp_n;

  assign bus.value_ready = ~r_pend_full;
  assign w_accept = bus.value_valid & ~r_pend_full;
  assign w_commit = w_frame_end & r_pend_full;

  // The digit-0 nibble of a new frame must come
  // from the word being committed on this edge.
  assign w_disp_nxt = w_commit ? r_pend : r_disp;
  assign w_dp_nxt   = w_commit ? r_dp_pend : r_dp_disp;
  assign w_nib = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] r_vis;

  assign w_vis_nxt = w_commit ?
    lz_visible(r_pend, r_dp_pend) : r_vis;

  // Display resets to 0, which shows digit 0 only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vis <= 8'h01;
    end else begin
      r_vis <= w_vis_nxt;
    end
  end
`else
  assign w_vis_nxt = '1;
`endif

  always_comb begin
    w_anode_nxt = ANODE_OFF;
    if (w_drive_nxt &&
        digit_en[w_idx_nxt] &&
        w_vis_nxt[w_idx_nxt]) begin
      w_anode_nxt[w_idx_nxt] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp      <= '0;
      r_pend      <= '0;
      r_dp_disp   <= '0;
      r_dp_pend   <= '0;
      r_pend_full <= 1'b0;
      r_hex       <= '0;
      r_anode_n   <= ANODE_OFF;
      r_dp_n      <= 1'b1;
    end else begin
      if (w_accept) begin
        r_pend    <= bus.value_in;
        r_dp_pend <= bus.dp_in;
      end
      r_disp    <= w_disp_nxt;
      r_dp_disp <= w_dp_nxt;
      if (w_accept) begin
        r_pend_full <= 1'b1;
      end else if (w_commit) begin
        r_pend_full <= 1'b0;
      end
      if (w_wrap) begin
        r_hex  <= w_nib;
        r_dp_n <= ~w_dp_nxt[w_idx_nxt];
      end
      r_anode_n <= w_anode_nxt;
    end
  end

  assign hex_out    = r_hex;
  assign anode_n    = r_anode_n;
  assign dp_n       = r_dp_n;
  assign frame_done = w_frame_end;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with TICK_DIV=8,
// BLANK_CYCLES=2 against a positional scan model.
module tb_seven_seg_scan_ctrl;

  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = TD * 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] digit_en;
  logic [3:0] hex_out;
  logic [7:0] anode_n;
  logic       dp_n;
  logic       frame_done;

  seven_seg_scan_ctrl_if bus();

  seven_seg_scan_ctrl #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (rst),
    .bus        (bus),
    .digit_en   (digit_en),
    .hex_out    (hex_out),
    .anode_n    (anode_n),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          m_n;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  logic [7:0]  m_dpd;
  logic [7:0]  m_dpp;
  logic [7:0]  m_en;
  logic [7:0]  m_vis;
  bit          m_full;
  bit          m_acc;
  int          m_commits;

  function automatic logic [7:0] ref_vis(
    input logic [31:0] v,
    input logic [7:0]  dp
  );
    int hi;
    logic [7:0] r;
    hi = 0;
    for (int k = 0; k < 8; k++)
      if (((v >> (4*k)) & 32'hF) != 0) hi = k;
    r = dp;
    for (int k = 0; k <= hi; k++) r[k] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    return r;
`else
    return r | 8'hFF;
`endif
  endfunction

  task automatic model_reset();
    m_n    = 0;
    m_disp = '0;
    m_pend = '0;
    m_dpd  = '0;
    m_dpp  = '0;
    m_full = 0;
    m_acc  = 0;
    m_en   = digit_en;
    m_vis  = ref_vis(32'h0, 8'h0);
  endtask

  // {anode_n, hex_out, dp_n, frame_done, value_ready}
  function automatic logic [14:0] exp_outs();
    int pos;
    int dig;
    logic [7:0]  an;
    logic [31:0] sh;
    pos = m_n % TD;
    dig = (m_n / TD) % 8;
    an  = 8'hFF;
    if (pos >= BC && m_en[dig] && m_vis[dig])
      an[dig] = 1'b0;
    sh = m_disp >> (4*dig);
    return {an, sh[3:0], ~m_dpd[dig],
            (pos == TD-1 && dig == 7), ~m_full};
  endfunction

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_acc = bus.value_valid && !m_full;
      if ((m_n % FRAME) == FRAME-1 && m_full) begin
        m_disp = m_pend;
        m_dpd  = m_dpp;
        m_full = 0;
        m_vis  = ref_vis(m_disp, m_dpd);
        m_commits++;
      end
      if (m_acc) begin
        m_pend = bus.value_in;
        m_dpp  = bus.dp_in;
        m_full = 1;
      end
      m_en = digit_en;
      m_n++;
    end
    @(negedge clk);
  endtask

  task automatic load_word(
    input  logic [31:0] v,
    input  logic [7:0]  dp,
    output bit          ok
  );
    int c0;
    bit took;
    ok   = 0;
    took = 0;
    c0   = m_commits;
    bus.value_in    = v;
    bus.dp_in       = dp;
    bus.value_valid = 1'b1;
    for (int i = 0; i < 4*FRAME; i++) begin
      advance();
      if (m_acc) begin
        took = 1;
        bus.value_valid = 1'b0;
      end
      if (took && m_commits != c0) begin
        ok = 1;
        break;
      end
    end
    bus.value_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    n_checks++;
    got = {anode_n, hex_out, dp_n,
           frame_done, bus.value_ready};
    if (got !== {8'hFF, 4'h0, 1'b1, 1'b0, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_held got=%h exp=%h",
               got, {8'hFF, 4'h0, 3'b101});
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      if (i > 0) advance();
      got = {anode_n, hex_out, dp_n,
             frame_done, bus.value_ready};
      n_checks++;
      if (got !== exp_outs()) begin
        n_errors++;
        $display("FAIL reset_run n=%0d got=%h exp=%h",
                 m_n, got, exp_outs());
      end
    end
  endtask

  task automatic test_scan();
    logic [14:0] got;
    int fs;
    int c0;
    int d;
    fs = -1;
    c0 = m_commits;
    bus.value_in    = 32'h1234_5678;
    bus.dp_in       = 8'h00;
    bus.value_valid = 1'b1;
    advance();
    bus.value_valid = 1'b0;
    n_checks++;
    if (bus.value_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL scan_ready_fall got=%b exp=0",
               bus.value_ready);
    end
    for (int i = 0; i < 3*FRAME; i++) begin
      advance();
      if (fs < 0 && m_commits != c0) fs = m_n;
      got = {anode_n, hex_out, dp_n,
             frame_done, bus.value_ready};
      n_checks++;
      if (got !== exp_outs()) begin
        n_errors++;
        $display("FAIL scan n=%0d got=%h exp=%h",
                 m_n, got, exp_outs());
      end
      n_checks++;
      if ($countones(~anode_n) > 1 ||
          ((m_n % TD) < BC && anode_n !== 8'hFF)) begin
        n_errors++;
        $display("FAIL anode_rule n=%0d got=%h",
                 m_n, anode_n);
      end
      if (fs >= 0 && m_n < fs + FRAME &&
          (m_n % TD) == 4) begin
        d = (m_n - fs) / TD;
        n_checks++;
        if (hex_out !== 4'(8 - d) ||
            anode_n !== (8'hFF ^ 8'(1 << d))) begin
          n_errors++;
          $display("FAIL scan_digit%0d got=%h/%h exp=%h/%h",
                   d, hex_out, anode_n, 4'(8 - d),
                   8'hFF ^ 8'(1 << d));
        end
      end
    end
    n_checks++;
    if (fs < 0) begin
      n_errors++;
      $display("FAIL scan_commit got=none exp=commit");
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] got;
    logic [31:0] w[2];
    logic [31:0] fw;
    logic [31:0] frames[$];
    int sent;
    int i0;
    int cnt0;
    w[0] = $urandom | 32'h8000_0001;
    w[1] = ~w[0];
    sent = 0;
    fw   = 'x;
    bus.dp_in       = 8'h00;
    bus.value_in    = w[0];
    bus.value_valid = 1'b1;
    for (int i = 0; i < 5*FRAME; i++) begin
      advance();
      if (m_acc) begin
        sent++;
        if (sent < 2) bus.value_in = w[sent];
        else bus.value_valid = 1'b0;
      end
      got = {anode_n, hex_out, dp_n,
             frame_done, bus.value_ready};
      n_checks++;
      if (got !== exp_outs()) begin
        n_errors++;
        $display("FAIL b2b n=%0d got=%h exp=%h",
                 m_n, got, exp_outs());
      end
      if ((m_n % TD) == 4) begin
        fw[((m_n / TD) % 8)*4 +: 4] = hex_out;
        if (((m_n / TD) % 8) == 7) begin
          frames.push_back(fw);
          fw = 'x;
        end
      end
    end
    bus.value_valid = 1'b0;
    i0   = -1;
    cnt0 = 0;
    foreach (frames[k]) begin
      if (frames[k] === w[0]) begin
        cnt0++;
        if (i0 < 0) i0 = k;
      end
    end
    n_checks++;
    if (cnt0 != 1 || i0 < 0 ||
        i0 + 1 >= frames.size() ||
        frames[i0+1] !== w[1]) begin
      n_errors++;
      $display("FAIL b2b_order got=%0d frames of w0 exp=1 then w1",
               cnt0);
    end
  endtask

  task automatic test_digit_en();
    logic [14:0] got;
    int fd[$];
    digit_en = 8'h0F;
    for (int i = 0; i < 2*FRAME + 8; i++) begin
      advance();
      got = {anode_n, hex_out, dp_n,
             frame_done, bus.value_ready};
      n_checks++;
      if (got !== exp_outs()) begin
        n_errors++;
        $display("FAIL den n=%0d got=%h exp=%h",
                 m_n, got, exp_outs());
      end
      if (((m_n / TD) % 8) >= 4) begin
        n_checks++;
        if (anode_n !== 8'hFF) begin
          n_errors++;
          $display("FAIL den_off n=%0d got=%h exp=ff",
                   m_n, anode_n);
        end
      end
      if (frame_done === 1'b1) fd.push_back(m_n);
    end
    n_checks++;
    if (fd.size() < 2 || fd[1] - fd[0] != FRAME) begin
      n_errors++;
      $display("FAIL den_period got=%0d pulses exp=period %0d",
               fd.size(), FRAME);
    end
    digit_en = 8'hFF;
  endtask

  task automatic test_reset_mid();
    logic [14:0] got;
    bit ok;
    load_word($urandom | 32'h1, 8'h5A, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rmid_load got=timeout exp=commit");
    end
    for (int i = 0; i < 2*FRAME; i++) begin
      if ((m_n % FRAME) == 0) break;
      advance();
    end
    bus.value_in    = $urandom;
    bus.value_valid = 1'b1;
    advance();
    bus.value_valid = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if ((m_n % FRAME) == 3*TD + 4) break;
      advance();
    end
    n_checks++;
    if (anode_n === 8'hFF || bus.value_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_pre got=%h/%b exp=lit/0",
               anode_n, bus.value_ready);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (anode_n !== 8'hFF || bus.value_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rmid_async got=%h/%b exp=ff/1",
               anode_n, bus.value_ready);
    end
    advance();
    advance();
    rst = 1'b0;
    for (int i = 0; i < 2*FRAME; i++) begin
      if (i > 0) advance();
      got = {anode_n, hex_out, dp_n,
             frame_done, bus.value_ready};
      n_checks++;
      if (got !== exp_outs()) begin
        n_errors++;
        $display("FAIL rmid n=%0d got=%h exp=%h",
                 m_n, got, exp_outs());
      end
    end
  endtask

  task automatic test_random();
    logic [14:0] got;
    for (int i = 0; i < 8*FRAME; i++) begin
      if ((m_n % FRAME) == 0)
        digit_en = 8'($urandom);
      if (!bus.value_valid &&
          $urandom_range(0, 15) == 0) begin
        bus.value_in    = $urandom;
        bus.dp_in       = 8'($urandom);
        bus.value_valid = 1'b1;
      end
      advance();
      if (m_acc) bus.value_valid = 1'b0;
      got = {anode_n, hex_out, dp_n,
             frame_done, bus.value_ready};
      n_checks++;
      if (got !== exp_outs()) begin
        n_errors++;
        $display("FAIL rand n=%0d got=%h exp=%h",
                 m_n, got, exp_outs());
      end
    end
    bus.value_valid = 1'b0;
    digit_en = 8'hFF;
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_lzb();
    logic [31:0] vals[3];
    logic [7:0]  dps[3];
    logic [7:0]  want[3];
    logic [7:0]  lit;
    logic [3:0]  h[2];
    bit ok;
    vals = '{32'h0000_00A0, 32'h0, 32'h0};
    dps  = '{8'h00, 8'h00, 8'h10};
    want = '{8'h03, 8'h01, 8'h11};
    for (int t = 0; t < 3; t++) begin
      load_word(vals[t], dps[t], ok);
      lit = 8'h00;
      h   = '{4'hx, 4'hx};
      for (int i = 0; i < FRAME; i++) begin
        lit = lit | ~anode_n;
        if ((m_n % TD) == 4 && ((m_n / TD) % 8) < 2)
          h[(m_n / TD) % 8] = hex_out;
        advance();
      end
      n_checks++;
      if (!ok || lit !== want[t]) begin
        n_errors++;
        $display("FAIL lzb_mask%0d got=%h exp=%h",
                 t, lit, want[t]);
      end
      if (t == 0) begin
        n_checks++;
        if (h[0] !== 4'h0 || h[1] !== 4'hA) begin
          n_errors++;
          $display("FAIL lzb_hex got=%h%h exp=a0",
                   h[1], h[0]);
        end
      end
    end
  endtask
`endif

  initial begin
    bus.value_in    = '0;
    bus.dp_in       = '0;
    bus.value_valid = 1'b0;
    digit_en        = 8'hFF;
    m_commits       = 0;
    model_reset();
    repeat (3) advance();
    test_reset();
    test_scan();
    test_back_to_back();
    test_digit_en();
    test_reset_mid();
    test_random();
`ifdef LEADING_ZERO_BLANK_EN
    test_lzb();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
